program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_if.sv | 31 +++
 rtl/program_loader.sv | 156 +++++++++++++++
 tb/tb_program_loader.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Byte-stream and program-memory write bus of the program loader.
// master: the environment side (byte source, memory).
// slave:  the loader side.
`timescale 1ns/1ps

interface program_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] mem_address;
    logic [7:0] mem_data;
    logic       mem_write_enable;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mem_address,
        input  mem_data,
        input  mem_write_enable
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mem_address,
        output mem_data,
        output mem_write_enable
    );
endinterface

// File: rtl/program_loader.sv
// program_loader: receives LEN_LO, LEN_HI, N data bytes (1..1024) and writes
// them to a 1024x8 program memory, holding the CPU until the load completes.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing mod-256
// checksum byte of the data bytes before DONE.
`timescale 1ns/1ps

module program_loader (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            restart,
    program_loader_if.slave bus,
    output logic            cpu_hold,
    output logic            done,
    output logic            error
);

    localparam logic [15:0] MAX_LEN = 16'd1024;

    typedef enum logic [2:0] {
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
`ifdef LOADER_CHECKSUM_EN
        ST_CHECKSUM,
`endif
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [10:0] r_count;        // data bytes accepted so far
    logic [10:0] r_length;       // validated length N (low byte staged in LEN_LO)
    logic [9:0]  r_mem_address;
    logic [7:0]  r_mem_data;
    logic        r_mem_we;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  r_sum;
`endif

    logic        w_in_ready;
    logic        w_xfer;
    logic        w_last;
    logic        w_restart;
    logic        w_len_ok;
    logic [15:0] w_len;
    logic [10:0] w_count_next;

    // Ready depends on state only, so the transfer term never loops through the FSM.
    assign w_in_ready   = (r_state != ST_DONE) && (r_state != ST_ERROR);
    assign w_xfer       = bus.in_valid && w_in_ready;
    assign w_restart    = restart && !w_in_ready;
    assign w_len        = {bus.in_data, r_length[7:0]};
    assign w_len_ok     = (w_len != 16'd0) && (w_len <= MAX_LEN);
    assign w_count_next = r_count + 11'd1;
    assign w_last       = (w_count_next == r_length);

    assign bus.in_ready         = w_in_ready;
    assign bus.mem_address      = r_mem_address;
    assign bus.mem_data         = r_mem_data;
    assign bus.mem_write_enable = r_mem_we;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential logic uses <= so every register sees pre-edge values.
        if (!reset_n) begin
            r_state <= ST_LEN_LO;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and state-derived status outputs.
    always_comb begin
        // NOTE: defaults first, so no path leaves an output unassigned (no latch).
        w_next_state = r_state;
        cpu_hold     = 1'b1;
        done         = 1'b0;
        error        = 1'b0;
        case (r_state)
            ST_LEN_LO: begin
                if (w_xfer) w_next_state = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (w_xfer) w_next_state = w_len_ok ? ST_DATA : ST_ERROR;
            end
            ST_DATA: begin
                if (w_xfer && w_last) begin
`ifdef LOADER_CHECKSUM_EN
                    w_next_state = ST_CHECKSUM;
`else
                    w_next_state = ST_DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECKSUM: begin
                if (w_xfer) w_next_state = (bus.in_data == r_sum) ? ST_DONE : ST_ERROR;
            end
`endif
            ST_DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
                if (w_restart) w_next_state = ST_LEN_LO;
            end
            ST_ERROR: begin
                error = 1'b1;
                if (w_restart) w_next_state = ST_LEN_LO;
            end
            default: begin
                w_next_state = ST_LEN_LO;
            end
        endcase
    end

    // Length capture, byte counter, checksum and the one-cycle write strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count       <= '0;
            r_length      <= '0;
            r_mem_address <= '0;
            r_mem_data    <= '0;
            r_mem_we      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_sum         <= '0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            if (w_restart) begin
                r_count  <= '0;
                r_length <= '0;
`ifdef LOADER_CHECKSUM_EN
                r_sum    <= '0;
`endif
            end else if (w_xfer) begin
                case (r_state)
                    ST_LEN_LO: r_length <= {3'b000, bus.in_data};
                    // Out-of-range lengths lead to ERROR, so truncation is harmless.
                    ST_LEN_HI: r_length <= w_len[10:0];
                    ST_DATA: begin
                        r_mem_we      <= 1'b1;
                        r_mem_address <= r_count[9:0];
                        r_mem_data    <= bus.in_data;
                        r_count       <= w_count_next;
`ifdef LOADER_CHECKSUM_EN
                        r_sum         <= r_sum + bus.in_data;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader. Works with and without
// LOADER_CHECKSUM_EN; checksum bytes are only sent when the macro is defined.
`timescale 1ns/1ps

module tb_program_loader;

    logic clk = 1'b0;
    logic reset_n;
    logic restart;
    logic cpu_hold;
    logic done;
    logic error;

    int checks = 0;
    int errors = 0;

    logic [9:0] wr_addr[$];
    logic [7:0] wr_data[$];

    program_loader_if bus ();

    program_loader u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .restart  (restart),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    // Record every cycle with the write strobe high, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.mem_write_enable === 1'b1) begin
            wr_addr.push_back(bus.mem_address);
            wr_data.push_back(bus.mem_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_write(input string tag, input int idx, input logic [9:0] a, input logic [7:0] d);
        if (idx < wr_addr.size()) begin
            check($sformatf("%s_addr", tag), 32'(wr_addr[idx]), 32'(a));
            check($sformatf("%s_data", tag), 32'(wr_data[idx]), 32'(d));
        end else begin
            check($sformatf("%s_missing", tag), wr_addr.size(), idx + 1);
        end
    endtask

    // Offer one byte for one edge; consecutive calls keep in_valid high.
    task automatic send(input logic [7:0] b);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic apply_reset();
        bus.in_valid = 1'b0;
        restart      = 1'b0;
        reset_n      = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        clear_log();
    endtask

    task automatic pulse_restart();
        bus.in_valid = 1'b0;
        restart      = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    int bad;

    initial begin
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        restart      = 1'b0;
        reset_n      = 1'b0;

        // Reset values, before any clock edge.
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_cpu_hold", cpu_hold, 1);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_we", bus.mem_write_enable, 0);
        check("rst_addr", bus.mem_address, 0);
        check("rst_data", bus.mem_data, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready_after", bus.in_ready, 1);
        clear_log();

        // Stream 03 00 A9 01 60 (+0A); restart held high mid-load is ignored.
        send(8'h03);
        send(8'h00);
        send(8'hA9);
        check("a_lat_we", bus.mem_write_enable, 1);
        check("a_lat_addr", bus.mem_address, 10'h000);
        check("a_lat_data", bus.mem_data, 8'hA9);
        restart = 1'b1;
        idle(3);
        restart = 1'b0;
        check("a_we_dropped", bus.mem_write_enable, 0);
        check("a_hold_ready", bus.in_ready, 1);
        check("a_hold_done", done, 0);
        send(8'h01);
        send(8'h60);
`ifdef LOADER_CHECKSUM_EN
        send(8'h0A);
`endif
        idle(2);
        check("a_strobes", wr_addr.size(), 3);
        check_write("a_w0", 0, 10'h000, 8'hA9);
        check_write("a_w1", 1, 10'h001, 8'h01);
        check_write("a_w2", 2, 10'h002, 8'h60);
        check("a_done", done, 1);
        check("a_error", error, 0);
        check("a_cpu_hold", cpu_hold, 0);
        check("a_in_ready", bus.in_ready, 0);

`ifdef LOADER_CHECKSUM_EN
        // Same stream with wrong checksum 0B.
        apply_reset();
        send(8'h03);
        send(8'h00);
        send(8'hA9);
        send(8'h01);
        send(8'h60);
        send(8'h0B);
        idle(2);
        check("b_strobes", wr_addr.size(), 3);
        check("b_error", error, 1);
        check("b_done", done, 0);
        check("b_cpu_hold", cpu_hold, 1);
        check("b_in_ready", bus.in_ready, 0);
`endif

        // Length 0, then length 1025 after a restart.
        apply_reset();
        send(8'h00);
        check("c0_err_early", error, 0);
        send(8'h00);
        check("c0_error", error, 1);
        idle(2);
        check("c0_strobes", wr_addr.size(), 0);
        check("c0_cpu_hold", cpu_hold, 1);
        pulse_restart();
        check("c_restart_err", error, 0);
        check("c_restart_ready", bus.in_ready, 1);
        send(8'h01);
        check("c1_err_early", error, 0);
        send(8'h04);
        check("c1_error", error, 1);
        idle(2);
        check("c1_strobes", wr_addr.size(), 0);
        check("c1_done", done, 0);

        // Maximum length 1024, back-to-back.
        apply_reset();
        send(8'h00);
        send(8'h04);
        for (int i = 0; i < 1024; i++) send(8'(i));
`ifdef LOADER_CHECKSUM_EN
        send(8'h00);
`endif
        idle(2);
        check("d_strobes", wr_addr.size(), 1024);
        check_write("d_last", 1023, 10'h3FF, 8'hFF);
        bad = 0;
        for (int i = 0; i < wr_addr.size(); i++) begin
            if (wr_addr[i] !== 10'(i) || wr_data[i] !== 8'(i)) bad++;
        end
        check("d_seq_mismatches", bad, 0);
        check("d_done", done, 1);
        check("d_error", error, 0);

        // Reset mid-load after 2 of 5 bytes, then a fresh one-byte stream.
        apply_reset();
        send(8'h05);
        send(8'h00);
        send(8'h11);
        send(8'h22);
        #1;
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("e_rst_we", bus.mem_write_enable, 0);
        check("e_rst_hold", cpu_hold, 1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("e_strobes_before", wr_addr.size(), 2);
        clear_log();
        send(8'h01);
        send(8'h00);
        send(8'hEA);
`ifdef LOADER_CHECKSUM_EN
        send(8'hEA);
`endif
        idle(2);
        check("e_strobes", wr_addr.size(), 1);
        check_write("e_w0", 0, 10'h000, 8'hEA);
        check("e_done", done, 1);

        // Bytes offered in DONE are dropped; restart then reload.
        clear_log();
        send(8'h77);
        send(8'h88);
        send(8'h99);
        idle(2);
        check("f_extra_strobes", wr_addr.size(), 0);
        check("f_still_done", done, 1);
        check("f_ready_low", bus.in_ready, 0);
        pulse_restart();
        check("f_restart_done", done, 0);
        check("f_restart_ready", bus.in_ready, 1);
        check("f_restart_hold", cpu_hold, 1);
        send(8'h02);
        send(8'h00);
        send(8'h5A);
        send(8'hC3);
`ifdef LOADER_CHECKSUM_EN
        send(8'h1D);
`endif
        idle(2);
        check("f_strobes", wr_addr.size(), 2);
        check_write("f_w0", 0, 10'h000, 8'h5A);
        check_write("f_w1", 1, 10'h001, 8'hC3);
        check("f_done", done, 1);
        check("f_error", error, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
